mem_req_ctrl: RTL and testbench
===============================

// Module: mem_req_ctrl
// PURPOSE
//  Initiator side of the single-port busy/stall memory protocol used by dual-ported sim memories.
//  - Accepts load/store requests from the core LSU or fetch unit over a valid/ready handshake.
//  - Drives one memory port (en/wen/addr/wdata) and stalls on mem_busy_i.
//  - Returns one response per accepted request.
//  - Memory is word-only, so byte and halfword stores are done as read-modify-write.
// PARAMETERS
//  TIMEOUT_CYCLES  16       consecutive busy cycles before abort (used only with MEM_REQ_TIMEOUT_EN)
//  MEM_BYTES       'h10000  size of the addressable window; addresses >= MEM_BYTES are errors
// PORTS
//  clk_i           in   1   clock
//  rst_n_i         in   1   reset, asynchronous, active-low
//  req_valid_i     in   1   request valid
//  req_ready_o     out  1   request accepted when valid&ready
//  req_we_i        in   1   1=store, 0=load
//  req_size_i      in   2   0=byte, 1=half, 2=word (3 = error)
//  req_unsigned_i  in   1   load zero-extends when 1, sign-extends when 0
//  req_addr_i      in   32  byte address
//  req_wdata_i     in   32  store data, right-aligned
//  resp_valid_o    out  1   one-cycle response pulse
//  resp_rdata_o    out  32  load result, extended; 0 for stores and errors
//  resp_err_o      out  1   misaligned, out of range, bad size, or timeout
//  mem_en_o        out  1   memory port enable
//  mem_wen_o       out  1   memory write enable
//  mem_addr_o      out  32  word-aligned memory address
//  mem_wdata_o     out  32  memory write data
//  mem_rdata_i     in   32  memory read data; valid when en&!wen&!busy
//  mem_busy_i      in   1   memory stall, combinational within the cycle
// BEHAVIOUR
//  - Reset: state IDLE; req_ready_o=1 after reset; every other output 0, including mem_addr_o.
//  - States: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
//  - IDLE: req_ready_o=1 and mem_en_o=0. mem_addr_o HOLDS its last value, so no new-address busy is triggered.
//  - On accept, check the request:
//    - misaligned (half: addr[0]; word: addr[1:0]!=0), size==3, or addr>=MEM_BYTES -> RESP with err=1 and no memory cycle;
//    - load -> RD;
//    - word store -> WR;
//    - byte or half store -> RMW_RD.
//  - Request fields (addr, size, wdata, unsigned) are registered at accept. mem_addr_o={addr[31:2],2'b00} from the next cycle.
//  - RD / RMW_RD: mem_en_o=1, mem_wen_o=0.
//    - While mem_busy_i=1: stay.
//    - First cycle with busy=0: capture mem_rdata_i. RD -> RESP; RMW_RD -> RMW_WR.
//  - WR / RMW_WR: mem_en_o=1. mem_wen_o = !mem_busy_i (combinational gate); the write commits on the edge where wen=1, then -> RESP.
//  - Merge rule: byte stores replace lane addr[1:0] with wdata[7:0]; half stores replace lane addr[1] with wdata[15:0].
//  - mem_addr_o is unchanged between RMW_RD and RMW_WR, so no second busy is triggered.
//  - RESP: resp_valid_o=1 for exactly one cycle, then IDLE. req_ready_o=0 in every non-IDLE state (one outstanding request max).
//  - Load extraction: byte lane addr[1:0] or half lane addr[1], then sign- or zero-extended to 32 bits per req_unsigned_i.
//  - Latency with busy=0 throughout:
//    - load or word store: accept at N -> resp_valid at N+2;
//    - RMW store: N+3;
//    - error: N+1.
//    - Each busy cycle adds 1.
//  - Back-to-back: a new request can be accepted in the cycle after RESP.
//  - Reset mid-operation: immediate return to IDLE. The in-flight request is dropped with no response; any write not yet committed never happens.
// CONFIGURATION
//  MEM_REQ_TIMEOUT_EN defined:
//    - a counter runs while any memory state sees mem_busy_i=1 and clears when busy=0;
//    - when it reaches TIMEOUT_CYCLES: go to RESP with err=1 and rdata=0; mem_wen_o is never raised;
//    - an RMW store that times out in RMW_RD performs no write.
//  MEM_REQ_TIMEOUT_EN undefined: no counter; waits on busy indefinitely; TIMEOUT_CYCLES is ignored.
// STRUCTURE
//  - mem_req_pkg: size enum (SZ_BYTE/SZ_HALF/SZ_WORD), state enum, and lane-select helper functions.
//  - Sub-module mem_lane_align (combinational): load extract/extend and store merge from addr[1:0], size, unsigned.
//  - mem_req_ctrl holds the FSM, the request registers, the read capture register and the timeout counter.
// TESTING
//  - Word load, addr 0x4, mem[1]=0xDEADBEEF, busy=0: resp at N+2, rdata=0xDEADBEEF, err=0.
//  - Signed byte load, addr 0x7, mem[1]=0x80FF1234: rdata=0xFFFFFF80. Same load with unsigned=1: rdata=0x00000080.
//  - Half store 0xABCD to addr 0x22, mem[8]=0x11223344, new 32B-aligned address gives busy=2 cycles:
//    - mem[8] becomes 0xABCD3344;
//    - exactly one wen pulse, with busy=0 on that cycle;
//    - resp at N+5.
//  - Misaligned word load at 0x6: resp at N+1, err=1, mem_en_o never asserted. addr 0x10000: err=1.
//  - Reset asserted in WR while busy=1: outputs go to 0 asynchronously, memory unchanged, no resp. Next request is served normally.
//  - MEM_REQ_TIMEOUT_EN, TIMEOUT_CYCLES=4, busy held high: err=1 at N+1+4+1, no wen. Without the macro: no resp while busy is held high.

Source files
------------

// File: rtl/mem_req_pkg.sv
// Shared types and lane helpers for the memory request controller.
package mem_req_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_BAD  = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    RMW_RD,
    RMW_WR,
    RESP
  } state_e;

  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] lane);
    return w[{lane, 3'b000} +: 8];
  endfunction

  function automatic logic [15:0] lane_half(input logic [31:0] w, input logic hi);
    return w[{hi, 4'b0000} +: 16];
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [1:0] a);
    case (sz)
      SZ_HALF: return a[0];
      SZ_WORD: return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module mem_lane_align
  import mem_req_pkg::*;
(
  input  logic [1:0]  lane,
  input  size_e       size,
  input  logic        zext,
  input  logic [31:0] rd_word,
  input  logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic [31:0] merged
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = lane_byte(rd_word, lane);
  assign h = lane_half(rd_word, lane[1]);

  always_comb begin
    ld_data = rd_word;
    merged  = rd_word;
    case (size)
      SZ_BYTE: begin
        ld_data = {{24{b[7] & ~zext}}, b};
        merged[{lane, 3'b000} +: 8] = st_data[7:0];
      end
      SZ_HALF: begin
        ld_data = {{16{h[15] & ~zext}}, h};
        merged[{lane[1], 4'b0000} +: 16] = st_data[15:0];
      end
      default: merged = st_data;
    endcase
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Load/store initiator for a single-port busy/stall memory; sub-word stores use RMW.
// Optional busy timeout abort is compiled in with MEM_REQ_TIMEOUT_EN.
module mem_req_ctrl
  import mem_req_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] MEM_BYTES      = 32'h10000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        mem_en_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_busy_i
);

  state_e      state;
  size_e       size_q, req_size;
  logic [31:0] addr_q, wdata_q, mem_wdata_q, resp_rdata_q;
  logic        zext_q, ready_q, en_q, resp_valid_q, resp_err_q;
  logic        req_bad, tmo_hit, wr_state;
  logic [31:0] ld_data, merged;

  assign req_size = size_e'(req_size_i);
  assign req_bad  = (req_size == SZ_BAD) || misaligned(req_size, req_addr_i[1:0]) ||
                    (req_addr_i >= MEM_BYTES);

  mem_lane_align u_align (
    .lane    (addr_q[1:0]),
    .size    (size_q),
    .zext    (zext_q),
    .rd_word (mem_rdata_i),
    .st_data (wdata_q),
    .ld_data (ld_data),
    .merged  (merged)
  );

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  logic [CW-1:0] tmo_cnt;
  logic          in_mem;

  assign in_mem = (state == RD) || (state == WR) || (state == RMW_RD) || (state == RMW_WR);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                tmo_cnt <= '0;
    else if (in_mem && mem_busy_i) tmo_cnt <= tmo_cnt + 1'b1;
    else                         tmo_cnt <= '0;
  end

  assign tmo_hit = in_mem && (tmo_cnt == CW'(TIMEOUT_CYCLES));
`else
  assign tmo_hit = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  // Write strobe is gated combinationally so the commit edge is the first non-busy one.
  assign wr_state = (state == WR) || (state == RMW_WR);
  assign mem_wen_o = wr_state && !mem_busy_i && !tmo_hit;

  assign req_ready_o  = ready_q;
  assign mem_en_o     = en_q;
  assign mem_addr_o   = {addr_q[31:2], 2'b00};
  assign mem_wdata_o  = mem_wdata_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      ready_q      <= 1'b1;
      en_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      addr_q       <= '0;
      size_q       <= SZ_BYTE;
      zext_q       <= 1'b0;
      wdata_q      <= '0;
      mem_wdata_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        IDLE: if (req_valid_i) begin
          addr_q  <= req_addr_i;
          size_q  <= req_size;
          zext_q  <= req_unsigned_i;
          wdata_q <= req_wdata_i;
          ready_q <= 1'b0;
          if (req_bad) begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
          end else begin
            en_q        <= 1'b1;
            mem_wdata_q <= req_wdata_i;
            if (!req_we_i)                state <= RD;
            else if (req_size == SZ_WORD) state <= WR;
            else                          state <= RMW_RD;
          end
        end
        RD, RMW_RD: begin
          if (tmo_hit) begin
            state        <= RESP;
            en_q         <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
          end else if (!mem_busy_i) begin
            if (state == RD) begin
              state        <= RESP;
              en_q         <= 1'b0;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= ld_data;
            end else begin
              // Address stays put into RMW_WR so the memory sees no new-address stall.
              state       <= RMW_WR;
              mem_wdata_q <= merged;
            end
          end
        end
        WR, RMW_WR: begin
          if (tmo_hit) begin
            state        <= RESP;
            en_q         <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
          end else if (!mem_busy_i) begin
            state        <= RESP;
            en_q         <= 1'b0;
            resp_valid_q <= 1'b1;
          end
        end
        RESP: begin
          state        <= IDLE;
          ready_q      <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          en_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl: byte-level reference model, stall-injecting memory.
module tb_mem_req_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0, rst_n = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_err, mem_en, mem_wen, mem_busy;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_req_ctrl #(.TIMEOUT_CYCLES(TMO), .MEM_BYTES(32'h10000)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .mem_en_o(mem_en), .mem_wen_o(mem_wen), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_busy_i(mem_busy)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    int          ens;
    int          wens;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, errors = 0;
  int          cyc = 0, en_cycles = 0, busy_len = 0;
  logic [31:0] mem [0:16383];
  logic [7:0]  ref_b [0:65535];

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    en_cycles <= mem_en ? en_cycles + 1 : 0;
  end

  // Memory: stalls for the first busy_len cycles of each enable window.
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 16384; i++) mem[i] <= init_word(i);
    end else if (mem_en && mem_wen) begin
      mem[mem_addr[15:2]] <= mem_wdata;
    end
  end

  assign mem_busy  = mem_en && (en_cycles < busy_len);
  assign mem_rdata = (mem_en && !mem_wen) ? mem[mem_addr[15:2]] : 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic we, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input int busy, input int n0);
    exp_t e;
    int nb;
    logic [31:0] v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e.rdata = '0; e.err = 1'b0; e.ens = 0; e.wens = 0;
    if (sz == 2'd3 || (addr % nb) != 0 || addr >= 32'h10000) begin
      e.err = 1'b1; e.cyc = n0 + 1;
      return e;
    end
`ifdef MEM_REQ_TIMEOUT_EN
    if (busy >= TMO) begin
      e.err = 1'b1; e.cyc = n0 + TMO + 2; e.ens = TMO + 1;
      return e;
    end
`endif
    if (we) begin
      for (int k = 0; k < nb; k++) ref_b[addr + k] = wd[8*k +: 8];
      e.wens = 1;
      e.cyc  = n0 + busy + ((nb < 4) ? 3 : 2);
    end else begin
      v = '0;
      for (int k = 0; k < nb; k++) v = v | (32'(ref_b[addr + k]) << (8 * k));
      if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
      e.rdata = v;
      e.cyc   = n0 + busy + 2;
    end
    e.ens = e.cyc - n0 - 1;
    return e;
  endfunction

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int busy, input bit expect_resp);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL ready_wait: req_ready got 0 expected 1 within 200 cycles");
      return;
    end
    busy_len     = busy;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    if (expect_resp) q.push_back(model(we, sz, uns, addr, wd, busy, cyc));
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d responses outstanding expected 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: counts port activity per transaction, compares on each response pulse.
  initial begin
    int en_cnt = 0, wen_cnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        en_cnt = 0; wen_cnt = 0;
      end else begin
        if (mem_en) en_cnt++;
        if (mem_en && mem_wen) begin
          wen_cnt++;
          chk("wen_while_busy", {31'b0, mem_busy}, 32'h0);
        end
        if (resp_valid) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_resp: got resp_valid=1 at cycle %0d expected none", cyc);
          end else begin
            e = q.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
            chk("resp_cycle", 32'(cyc), 32'(e.cyc));
            chk("en_cycles", 32'(en_cnt), 32'(e.ens));
            chk("wen_pulses", 32'(wen_cnt), 32'(e.wens));
          end
          en_cnt = 0; wen_cnt = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [1:0]  sz;
    int          r;
    for (int i = 0; i < 16384; i++) begin
      d = init_word(i);
      for (int k = 0; k < 4; k++) ref_b[4*i + k] = d[8*k +: 8];
    end

    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_en", {31'b0, mem_en}, 32'h0);
    chk("rst_wen", {31'b0, mem_wen}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    issue(1'b1, 2'd2, 1'b0, 32'h4,  32'hDEADBEEF, 0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h4,  32'h0,        0, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'h4,  32'h80FF1234, 1, 1'b1);
    issue(1'b0, 2'd0, 1'b0, 32'h7,  32'h0,        0, 1'b1);
    issue(1'b0, 2'd0, 1'b1, 32'h7,  32'h0,        0, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, 0, 1'b1);
    issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000ABCD, 2, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h6,  32'h0,        0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h10000, 32'h0,     0, 1'b1);
    issue(1'b0, 2'd3, 1'b0, 32'h8,  32'h0,        0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'hFFFC, 32'h0,      1, 1'b1);
    drain();
    chk("half_rmw_word", mem[8], 32'hABCD3344);

    // Abort a stalled word store with reset: no write, no response.
    issue(1'b1, 2'd2, 1'b0, 32'h40, 32'h12345678, 1000, 1'b0);
    repeat (3) @(negedge clk);
    chk("stalled_en", {31'b0, mem_en}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready", {31'b0, req_ready}, 32'h1);
    chk("abort_en", {31'b0, mem_en}, 32'h0);
    chk("abort_wen", {31'b0, mem_wen}, 32'h0);
    chk("abort_addr", mem_addr, 32'h0);
    chk("abort_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    busy_len = 0;
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0, 1'b1);

    // Long stall: aborts with the timeout build, otherwise completes after the stall.
    issue(1'b1, 2'd2, 1'b0, 32'h50, 32'hCAFEF00D, 30, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h50, 32'h0, 0, 1'b1);

    repeat (60) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'h10000 + $urandom_range(0, 255);
      else if (r == 1) a = 32'hFFFC + $urandom_range(0, 3);
      else             a = $urandom_range(0, 127);
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
            $urandom_range(0, 3), 1'b1);
    end
    drain();

    for (int i = 0; i < 64; i++)
      chk("mem_word", mem[i], {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]});
    chk("mem_top_word", mem[16383], {ref_b[65535], ref_b[65534], ref_b[65533], ref_b[65532]});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
